// File: rtl/ika2151_dac_pkg.sv
// Shared field layout and types for the YM3012-style serial DAC receiver.
package ika2151_dac_pkg;
  localparam int MANT_LSB      = 3;
  localparam int MANT_W        = 10;
  localparam int EXP_LSB       = 13;
  localparam int EXP_W         = 3;
  localparam int WORD_BITS_DEF = 16;

  typedef struct packed {
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
  } fpword_t;
endpackage

// File: rtl/ika2151_dac_rx_if.sv
// Serial input and PCM output bundle between the synth core side and the receiver.
interface ika2151_dac_rx_if;
  logic        i_phi1_PCEN_n;
  logic        i_SO;
  logic        i_SH1;
  logic        i_SH2;
  logic [15:0] o_CH1;
  logic [15:0] o_CH2;
  logic        o_CH1_VALID;
  logic        o_CH2_VALID;
  logic        o_FRAME_ERR;

  modport master (
    output i_phi1_PCEN_n, i_SO, i_SH1, i_SH2,
    input  o_CH1, o_CH2, o_CH1_VALID, o_CH2_VALID, o_FRAME_ERR
  );
  modport slave (
    input  i_phi1_PCEN_n, i_SO, i_SH1, i_SH2,
    output o_CH1, o_CH2, o_CH1_VALID, o_CH2_VALID, o_FRAME_ERR
  );
endinterface

// File: rtl/ika2151_fp2lin.sv
// Floating-point DAC word (3-bit exponent, 10-bit signed mantissa) to 16-bit linear PCM.
module ika2151_fp2lin
  import ika2151_dac_pkg::*;
(
  input  fpword_t     fp,
  output logic [15:0] pcm
);
  logic signed [15:0] mext;

  always_comb begin
    mext = {{(16-MANT_W){fp.m[MANT_W-1]}}, fp.m};
    // E=1 is the unscaled mantissa; E=7 peaks at 0x7FC0 / 0x8000, so no overflow
    pcm  = (fp.e == '0) ? 16'h0000 : 16'(mext <<< (fp.e - 3'd1));
  end
endmodule

// File: rtl/ika2151_dac_rx.sv
// Deserializes SO on phi1 ticks, latches on SH1/SH2 falls, and emits linear PCM one clock later.
module ika2151_dac_rx
  import ika2151_dac_pkg::*;
#(
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int ERR_STICKY = 0
) (
  input  logic          i_EMUCLK,
  input  logic          i_MRST_n,
  ika2151_dac_rx_if.slave bus
);
  localparam logic [4:0] THR = 5'(WORD_BITS-1);

  logic                  tick;
  logic [15:0]           sr;
  logic                  sh1_d, sh2_d;
  logic [4:0]            bitcnt;
  logic                  seen;
  logic [1:0]            fall, pend, vld;
  logic                  err, err_pend, frame_err;
  fpword_t [1:0]         cap;
  logic [1:0][15:0]      pcm, ch;

  assign tick    = ~bus.i_phi1_PCEN_n;
  assign fall[0] = tick & sh1_d & ~bus.i_SH1;
  assign fall[1] = tick & sh2_d & ~bus.i_SH2;
  // short word or colliding strobes; the very first fall after reset has no reference
  assign err     = (|fall) & seen & ((bitcnt < THR) | (&fall));

  for (genvar i = 0; i < 2; i++) begin : g_cvt
    ika2151_fp2lin u_cvt (.fp(cap[i]), .pcm(pcm[i]));
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      sr        <= '0;
      sh1_d     <= 1'b0;
      sh2_d     <= 1'b0;
      bitcnt    <= '0;
      seen      <= 1'b0;
      cap       <= '0;
      pend      <= '0;
      err_pend  <= 1'b0;
      vld       <= '0;
      ch        <= '0;
      frame_err <= 1'b0;
    end else begin
      // output stage runs on every edge
      vld      <= pend;
      pend     <= '0;
      err_pend <= 1'b0;
      for (int i = 0; i < 2; i++)
        if (pend[i]) ch[i] <= pcm[i];
      frame_err <= (ERR_STICKY != 0) ? (frame_err | err_pend) : err_pend;

      if (tick) begin
        sr     <= {bus.i_SO, sr[15:1]};
        sh1_d  <= bus.i_SH1;
        sh2_d  <= bus.i_SH2;
        bitcnt <= (bitcnt == 5'd31) ? bitcnt : bitcnt + 5'd1;
        // capture uses sr before this tick's shift
        for (int i = 0; i < 2; i++)
          if (fall[i]) begin
            cap[i]  <= sr[EXP_LSB+EXP_W-1:MANT_LSB];
            pend[i] <= 1'b1;
          end
        if (|fall) begin
          bitcnt   <= '0;
          seen     <= 1'b1;
          err_pend <= err;
        end
      end
    end
  end

  assign bus.o_CH1       = ch[0];
  assign bus.o_CH2       = ch[1];
  assign bus.o_CH1_VALID = vld[0];
  assign bus.o_CH2_VALID = vld[1];
  assign bus.o_FRAME_ERR = frame_err;
endmodule

// File: doc/ika2151_dac_rx.md
Name: ika2151_dac_rx

Overview:
- Receiving end of the chip's serial audio output: the counterpart of the YM3012-style DAC that listens on SO/SH1/SH2.
- Deserializes the LSB-first serial word on i_SO and latches it on the falling edges of SH1 (channel 1) and SH2 (channel 2).
- Converts the 10-bit mantissa / 3-bit exponent floating-point word into 16-bit signed linear PCM.
- Sits beside the synth core inside the emulator wrapper. It lets the FPGA take digital audio directly, without an external DAC.

Parameters:
- WORD_BITS, 16, serial bits per channel word. The block is specified for 16 only; other values are unsupported.
- ERR_STICKY, 0, 1 = o_FRAME_ERR holds until reset; 0 = o_FRAME_ERR is a 1-cycle pulse.

Ports:
- i_EMUCLK  in  1  emulator master clock; all state on its rising edge
- i_MRST_n  in  1  asynchronous active-low reset
- i_phi1_PCEN_n  in  1  phi1 positive-edge clock enable (active low); all serial sampling happens only on these ticks
- i_SO  in  1  serial data, LSB first
- i_SH1  in  1  channel 1 sample-hold strobe
- i_SH2  in  1  channel 2 sample-hold strobe
- o_CH1  out  16  channel 1 linear PCM, two's complement
- o_CH2  out  16  channel 2 linear PCM, two's complement
- o_CH1_VALID  out  1  one-EMUCLK pulse when o_CH1 updates
- o_CH2_VALID  out  1  one-EMUCLK pulse when o_CH2 updates
- o_FRAME_ERR  out  1  framing error indication

Behaviour:
- Reset (async assert, release on EMUCLK): all outputs 0; shift register 0; SH history registers 0; bit counter 0; pipeline valid bits 0.
- Tick: an EMUCLK edge with i_phi1_PCEN_n = 0. No state changes on non-tick edges except the output stage.
- Per tick:
  - sr <= {i_SO, sr[15:1]} (right shift, so the first bit received ends in sr[0]).
  - sh1_d <= i_SH1; sh2_d <= i_SH2.
  - bitcnt <= saturating increment (5-bit, saturates at 31).
- Field layout after 16 shifts: sr[2:0] dummy (ignored); sr[12:3] mantissa M (10-bit two's complement); sr[15:13] exponent E.
- SHn falling edge: a tick where sh{n}_d = 1 and i_SH{n} = 0.
- Stage 1, on that same tick:
  - cap{n} <= sr[15:3] using sr before this tick's shift (the bit on i_SO at the falling tick is not part of the word).
  - pend{n} <= 1.
  - bitcnt <= 0.
- Stage 2, on the next EMUCLK edge (tick or not):
  - o_CH{n} <= fp2lin(cap{n}); o_CH{n}_VALID <= 1; pend{n} <= 0.
  - Otherwise o_CH{n}_VALID <= 0.
  - Latency: output valid 1 EMUCLK after the detecting tick.
- fp2lin:
  - E = 0 -> 16'h0000.
  - E = 1..7 -> sign-extend M to 16 bits, then arithmetic shift left by (E-1).
  - No overflow is possible: range 0x8000..0x7FC0.
- Framing error, raised on an SH falling tick when either:
  - bitcnt < WORD_BITS-1 at that tick (fewer than 16 bits since the previous fall), or
  - SH1 and SH2 fall on the same tick.
  - Except: the first SH fall after reset never flags.
- Simultaneous SH1/SH2 fall: both channels capture the same word, both VALID pulse together, and o_FRAME_ERR is raised.
- ERR_STICKY = 0: o_FRAME_ERR is a 1-EMUCLK pulse aligned with the VALID pulse. ERR_STICKY = 1: it stays high until reset.
- SH held high indefinitely: no latch; bitcnt saturates; no error.
- SH rising edges have no effect.
- Reset mid-word: the partial word is discarded; any pending stage-2 update is cancelled (no VALID pulse).

Decomposition:
- Package ika2151_dac_pkg:
  - field constants MANT_LSB = 3, MANT_W = 10, EXP_LSB = 13, EXP_W = 3, WORD_BITS_DEF = 16
  - typedef fpword_t (13-bit {E, M}).
- One sub-module, ika2151_fp2lin: purely combinational fpword_t -> 16-bit signed. It is instantiated twice, or once shared behind a mux because stage 2 handles one channel per edge except in the error case. The spec prefers two instances.

Test Plan:
- Reset then 16-bit word: dummy 000, M = 0x1FF, E = 7, SH1 falls after bit 16 -> o_CH1 = 0x7FC0, o_CH1_VALID pulse 1 EMUCLK after the fall tick, o_FRAME_ERR = 0.
- Boundary words on SH2:
  - M = 0x200, E = 7 -> o_CH2 = 0x8000.
  - M = 0x3FF, E = 1 -> o_CH2 = 0xFFFF.
  - M = 0x155, E = 0 -> o_CH2 = 0x0000.
- Continuous frames alternating SH1/SH2, 32 ticks apart, with random words -> outputs match the reference model over 1000 words; o_FRAME_ERR never asserts.
- Phi1 enable gaps: insert non-tick EMUCLK cycles between ticks -> identical results; no shift occurs on non-tick edges.
- Short word: SH1 falls only 8 ticks after the previous SH2 fall -> o_FRAME_ERR asserts. With ERR_STICKY = 1 it stays high until i_MRST_n is asserted.
- SH1 and SH2 fall on the same tick -> o_CH1 == o_CH2, both VALID pulses, o_FRAME_ERR = 1.
- Assert i_MRST_n low mid-word and on the stage-2 edge -> all outputs read 0 immediately, with no VALID pulse.
